am_modulator: RTL and testbench

Transmit-side AM modulator for the SDR datapath. Accepts signed 16-bit audio samples over a valid/ready handshake and applies modulation depth and carrier offset using one registered multiply. It saturates the envelope and quantises it to 8 bits. Optionally it rotates successive samples by fs/4 to place the carrier off DC, then presents signed 8-bit I/Q to the upconversion stage over a valid/ready handshake.

---
 rtl/am_modulator_if.sv | 21 ++
 rtl/am_modulator.sv | 106 ++++++++++
 tb/tb_am_modulator.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/am_modulator_if.sv
// Stream bundle for am_modulator: audio samples in, signed 8-bit I/Q out.
// master drives audio and iq_ready; slave is the modulator.
interface am_modulator_if;
  logic signed [15:0] audio_in;
  logic               audio_valid;
  logic               audio_ready;
  logic signed [7:0]  i_out;
  logic signed [7:0]  q_out;
  logic               iq_valid;
  logic               iq_ready;

  modport master (
    output audio_in, audio_valid, iq_ready,
    input  audio_ready, i_out, q_out, iq_valid
  );

  modport slave (
    input  audio_in, audio_valid, iq_ready,
    output audio_ready, i_out, q_out, iq_valid
  );
endinterface

// File: rtl/am_modulator.sv
// AM modulator: one sample in flight, depth multiply, carrier add, saturate to 8 bits,
// optional fs/4 rotation onto I/Q.
module am_modulator #(
  parameter logic        [7:0]  DEPTH   = 8'd128,
  parameter logic signed [15:0] CARRIER = 16'sd8192,
  parameter bit                 ROTATE  = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  am_modulator_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StMul, StAcc, StRot, StHold} state_e;

  state_e             r_state, w_state_next;
  logic signed [15:0] r_sample;
  logic signed [24:0] r_product;
  logic signed [7:0]  r_env;
  logic        [1:0]  r_ph;
  logic signed [7:0]  r_i, r_q;
  logic               r_iq_valid;

  logic signed [24:0] w_product;
  logic signed [16:0] w_shifted;
  logic signed [16:0] w_env;
  logic signed [15:0] w_env_sat;
  logic signed [7:0]  w_a;
  logic signed [7:0]  w_neg_a;
  logic               w_idle, w_accept, w_load, w_done;

  // DEPTH gets a zero sign bit so the multiply stays signed x unsigned.
  assign w_product = r_sample * $signed({1'b0, DEPTH});
  // Dropping the low 8 bits is an arithmetic shift toward -inf.
  assign w_shifted = r_product[24:8];
  assign w_env     = w_shifted + $signed({CARRIER[15], CARRIER});

  always_comb begin
    if (w_env > 17'sd32767)       w_env_sat = 16'sh7fff;
    else if (w_env < -17'sd32768) w_env_sat = 16'sh8000;
    else                          w_env_sat = w_env[15:0];
  end

  assign w_a     = w_env_sat[15:8];
  assign w_neg_a = (r_env == 8'sh80) ? 8'sh7f : -r_env;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (bus.audio_valid) w_state_next = StMul;
      StMul:   w_state_next = StAcc;
      StAcc:   w_state_next = StRot;
      StRot:   w_state_next = StHold;
      StHold:  if (r_iq_valid && bus.iq_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // State-decoded controls
  always_comb begin
    w_idle   = (r_state == StIdle);
    w_accept = w_idle && bus.audio_valid;
    w_load   = (r_state == StRot);
    w_done   = (r_state == StHold) && r_iq_valid && bus.iq_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample   <= '0;
      r_product  <= '0;
      r_env      <= '0;
      r_ph       <= '0;
      r_i        <= '0;
      r_q        <= '0;
      r_iq_valid <= 1'b0;
    end else begin
      if (w_accept)           r_sample  <= bus.audio_in;
      if (r_state == StMul)   r_product <= w_product;
      if (r_state == StAcc)   r_env     <= w_a;
      if (w_load) begin
        case (r_ph)
          2'd0: begin r_i <= r_env;   r_q <= '0;      end
          2'd1: begin r_i <= '0;      r_q <= r_env;   end
          2'd2: begin r_i <= w_neg_a; r_q <= '0;      end
          default: begin r_i <= '0;   r_q <= w_neg_a; end
        endcase
        r_iq_valid <= 1'b1;
        if (ROTATE) r_ph <= r_ph + 2'd1;
      end else if (w_done) begin
        r_iq_valid <= 1'b0;
      end
    end
  end

  assign bus.audio_ready = w_idle && rst_n;
  assign bus.i_out       = r_i;
  assign bus.q_out       = r_q;
  assign bus.iq_valid    = r_iq_valid;

endmodule

// File: tb/tb_am_modulator.sv
// Directed bench for am_modulator: four instances cover default, saturating-carrier
// and fixed-phase builds.
module tb_am_modulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance 0: defaults, 1: DEPTH 255 / +30000, 2: DEPTH 255 / -30000, 3: ROTATE 0
  localparam logic [31:0] DEPTHS   = {8'd128, 8'd255, 8'd255, 8'd128};
  localparam logic [63:0] CARRIERS = 64'h2000_8AD0_7530_2000;
  localparam logic [3:0]  ROTS     = 4'b0111;

  logic [63:0] t_audio;
  logic [3:0]  t_valid, t_iqr, t_ready, t_ivalid;
  logic [31:0] t_ip, t_qp;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    am_modulator_if u_if ();
    assign u_if.audio_in    = t_audio[g*16 +: 16];
    assign u_if.audio_valid = t_valid[g];
    assign u_if.iq_ready    = t_iqr[g];
    assign t_ready[g]       = u_if.audio_ready;
    assign t_ivalid[g]      = u_if.iq_valid;
    assign t_ip[g*8 +: 8]   = u_if.i_out;
    assign t_qp[g*8 +: 8]   = u_if.q_out;

    am_modulator #(
      .DEPTH  (DEPTHS[g*8 +: 8]),
      .CARRIER(CARRIERS[g*16 +: 16]),
      .ROTATE (ROTS[g])
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (u_if)
    );
  end

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int k;
    int audio;
    int ei;
    int eq;
  } vec_t;
  vec_t vecs[$];

  function automatic int oi(input int k);
    return int'($signed(t_ip[k*8 +: 8]));
  endfunction

  function automatic int oq(input int k);
    return int'($signed(t_qp[k*8 +: 8]));
  endfunction

  task automatic check(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  // Called at a negedge with the instance idle; runs one full transaction.
  task automatic send(input int k, input int s, input int ei, input int eq, input string nm);
    int cyc = 0;
    while (!t_ready[k] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, " ready"}, int'(t_ready[k]), 1);
    t_audio[k*16 +: 16] = 16'(s);
    t_valid[k] = 1'b1;
    t_iqr[k]   = 1'b1;
    @(negedge clk);              // after E0
    t_valid[k] = 1'b0;
    @(negedge clk);              // after E1
    @(negedge clk);              // after E2
    check({nm, " early valid"}, int'(t_ivalid[k]), 0);
    @(negedge clk);              // after E3
    check({nm, " valid"}, int'(t_ivalid[k]), 1);
    check({nm, " I"}, oi(k), ei);
    check({nm, " Q"}, oq(k), eq);
    @(negedge clk);              // after E4
    check({nm, " ready again"}, int'(t_ready[k]), 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    t_audio = '0;
    t_valid = '0;
    t_iqr   = '0;

    // Instance 0, default build
    vecs.push_back('{0, 0, 32, 0});
    vecs.push_back('{0, 16384, 0, 64});
    vecs.push_back('{0, -32768, 32, 0});
    vecs.push_back('{0, 0, 0, -32});
    vecs.push_back('{0, 0, 32, 0});
    vecs.push_back('{0, 0, 0, 32});
    vecs.push_back('{0, 0, -32, 0});
    vecs.push_back('{0, 0, 0, -32});
    vecs.push_back('{0, 0, 32, 0});
    // Positive saturation
    vecs.push_back('{1, 32767, 127, 0});
    // Negative carrier: floor(-30000/256) = -118, then -(-128) saturates to 127
    vecs.push_back('{2, 0, -118, 0});
    vecs.push_back('{2, 0, 0, -118});
    vecs.push_back('{2, -32768, 127, 0});
    for (int i = 0; i < 8; i++) vecs.push_back('{3, 16384, 64, 0});

    #12;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst%0d I", k), oi(k), 0);
      check($sformatf("rst%0d Q", k), oq(k), 0);
      check($sformatf("rst%0d valid", k), int'(t_ivalid[k]), 0);
      check($sformatf("rst%0d ready", k), int'(t_ready[k]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    foreach (vecs[i]) send(vecs[i].k, vecs[i].audio, vecs[i].ei, vecs[i].eq,
                           $sformatf("vec%0d", i));

    // Backpressure on instance 0 (phase 1 next), audio_valid held high throughout
    begin
      int cyc = 0;
      t_audio[15:0] = 16'sd0;
      t_valid[0] = 1'b1;
      t_iqr[0]   = 1'b0;
      @(negedge clk);
      while (!t_ivalid[0] && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      check("bp valid", int'(t_ivalid[0]), 1);
      check("bp I", oi(0), 0);
      check("bp Q", oq(0), 32);
      repeat (10) begin
        @(negedge clk);
        check("bp hold I", oi(0), 0);
        check("bp hold Q", oq(0), 32);
        check("bp hold valid", int'(t_ivalid[0]), 1);
        check("bp hold ready", int'(t_ready[0]), 0);
      end
      t_iqr[0] = 1'b1;
      @(negedge clk);
      check("bp release ready", int'(t_ready[0]), 1);
      check("bp release valid", int'(t_ivalid[0]), 0);
      t_valid[0] = 1'b0;
      @(negedge clk);
      check("bp no second sample", int'(t_ready[0]), 1);
      send(0, 0, -32, 0, "bp next phase");
    end

    // Reset while instance 0 is in MUL
    t_audio[15:0] = 16'sd16384;
    t_valid[0] = 1'b1;
    t_iqr[0]   = 1'b1;
    @(negedge clk);
    t_valid[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst I", oi(0), 0);
    check("midrst Q", oq(0), 0);
    check("midrst valid", int'(t_ivalid[0]), 0);
    check("midrst ready", int'(t_ready[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("midrst discarded", int'(t_ivalid[0]), 0);
    end
    send(0, 0, 32, 0, "after rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
